// File: rtl/grf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_arb_pkg
// Description : Shared definitions for the GRF write-port arbiter: FSM state
//               encoding, B-queue depth, the hard-wired-zero register address
//               and the queued-entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_arb_pkg;

    // Arbiter FSM encoding
    localparam logic [0:0] c_NORM  = 1'b0;
    localparam logic [0:0] c_FORCE = 1'b1;

    // Depth of the B-request queue
    localparam int c_FIFO_DEPTH = 2;

    // Register $0 is hard-wired to zero; writes to it are dropped
    localparam logic [4:0] c_ADDR_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } grf_arb_entry_t;

endpackage
`default_nettype wire

// File: rtl/grf_arb_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : grf_arb_fifo2
// Description : Shallow shift-style queue for B write requests. Entry 0 is
//               always the head; a pop shifts everything down one slot and a
//               push lands in the first free slot after that shift, so a push
//               and a pop on the same edge keep the occupancy unchanged.
//               Pushes are ignored while full, even when popping.
// Ports       : clk, reset (sync, active-low)
//               i_push, i_din   - enqueue request and payload
//               i_pop           - dequeue the head (only when non-empty)
//               o_full, o_empty - registered occupancy flags
//               o_head          - current head entry
//               o_valid, o_addr - per-entry valid bits and address taps
// Revision    : 1.0 - initial release
// ============================================================================
module grf_arb_fifo2
    import grf_arb_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_push,
    input  grf_arb_entry_t                    i_din,
    input  logic                              i_pop,
    output logic                              o_full,
    output logic                              o_empty,
    output grf_arb_entry_t                    o_head,
    output logic [c_FIFO_DEPTH-1:0]           o_valid,
    output logic [c_FIFO_DEPTH-1:0][4:0]      o_addr
);

    logic [c_FIFO_DEPTH-1:0] r_valid;
    grf_arb_entry_t          r_entry     [c_FIFO_DEPTH];
    logic [c_FIFO_DEPTH-1:0] w_valid_nxt;
    grf_arb_entry_t          w_entry_nxt [c_FIFO_DEPTH];
    logic                    w_push_ok;
    logic                    w_placed;

    assign w_push_ok = i_push && !r_valid[c_FIFO_DEPTH-1];

    always_comb begin
        w_valid_nxt = r_valid;
        w_placed    = 1'b0;
        for (int i = 0; i < c_FIFO_DEPTH; i++) begin
            w_entry_nxt[i] = r_entry[i];
        end
        if (i_pop) begin
            for (int i = 0; i < c_FIFO_DEPTH - 1; i++) begin
                w_entry_nxt[i] = r_entry[i+1];
                w_valid_nxt[i] = r_valid[i+1];
            end
            w_valid_nxt[c_FIFO_DEPTH-1] = 1'b0;
        end
        if (w_push_ok) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                if (!w_placed && !w_valid_nxt[i]) begin
                    w_entry_nxt[i] = i_din;
                    w_valid_nxt[i] = 1'b1;
                    w_placed       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Payload needs no reset: it is only observed through r_valid
    always_ff @(posedge clk) begin
        r_entry <= w_entry_nxt;
    end

    assign o_full  = r_valid[c_FIFO_DEPTH-1];
    assign o_empty = !r_valid[0];
    assign o_head  = r_entry[0];
    assign o_valid = r_valid;

    generate
        for (genvar gi = 0; gi < c_FIFO_DEPTH; gi++) begin : g_tap
            assign o_addr[gi] = r_entry[gi].addr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/grf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grf_wport_arbiter
// Description : Arbitrates the single GRF write port between the pipeline
//               writeback (A, zero latency, no backpressure) and results of
//               multi-cycle units (B, queued). A wins in NORM; a queued B head
//               that has been blocked MAX_WAIT cycles is forced through in a
//               one-cycle FORCE state that stalls the pipeline WB stage.
// Config      : GRF_ARB_HAZARD_EN - when defined, q_hazard reports whether
//               q_addr matches a pending B write; otherwise tied to 0.
// Ports       : clk, reset (sync, active-low)
//               a_we/a_addr/a_data/a_pc         - A requester
//               b_valid/b_addr/b_data/b_pc      - B requester, b_ready accept
//               writeEn/WAddr/WData/PC          - GRF write port
//               stall                           - hold WB stage this cycle
//               q_addr/q_hazard                 - pending-write hazard query
// Revision    : 1.0 - initial release
// ============================================================================
module grf_wport_arbiter
    import grf_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic [31:0] b_pc,
    output logic        b_ready,
    output logic        writeEn,
    output logic [4:0]  WAddr,
    output logic [31:0] WData,
    output logic [31:0] PC,
    output logic        stall,
    input  logic [4:0]  q_addr,
    output logic        q_hazard
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic [0:0]                      r_state;
    logic [0:0]                      w_state_nxt;
    logic [3:0]                      r_wait;
    logic [3:0]                      w_wait_nxt;
    logic [3:0]                      w_wait_inc;
    logic                            w_a_req;
    logic                            w_b_accept;
    logic                            w_push;
    logic                            w_grant_a;
    logic                            w_grant_b;
    logic                            w_full;
    logic                            w_empty;
    grf_arb_entry_t                  w_head;
    grf_arb_entry_t                  w_din;
    logic [c_FIFO_DEPTH-1:0]         w_valid;
    logic [c_FIFO_DEPTH-1:0][4:0]    w_addr_tap;

    // While reset is held the FIFO is being cleared, so advertise the
    // post-reset value rather than the stale full flag.
    assign b_ready    = !reset || !w_full;
    assign w_b_accept = b_valid && b_ready;
    assign w_push     = w_b_accept && (b_addr != c_ADDR_ZERO);
    assign w_a_req    = a_we && (a_addr != c_ADDR_ZERO);
    assign w_wait_inc = r_wait + 4'd1;
    assign w_din      = '{addr: b_addr, data: b_data, pc: b_pc};

    grf_arb_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_grant_b),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_addr  (w_addr_tap)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_NORM;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        if (r_state == c_FORCE) begin
            w_grant_b   = !w_empty;
            w_state_nxt = c_NORM;
            w_wait_nxt  = 4'd0;
        end else begin
            if (w_a_req) begin
                w_grant_a = 1'b1;
            end else if (!w_empty) begin
                w_grant_b = 1'b1;
            end
            if (w_empty || w_grant_b) begin
                w_wait_nxt = 4'd0;
            end else begin
                w_wait_nxt = w_wait_inc;
                // The edge that brings the counter to MAX_WAIT enters FORCE
                if (w_wait_inc == c_MAX_WAIT) begin
                    w_state_nxt = c_FORCE;
                end
            end
        end
        // Outputs and the dequeue are suppressed during the reset cycle
        if (!reset) begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end
    end

    always_comb begin
        writeEn = 1'b0;
        WAddr   = 5'd0;
        WData   = 32'd0;
        PC      = 32'd0;
        if (w_grant_a) begin
            writeEn = 1'b1;
            WAddr   = a_addr;
            WData   = a_data;
            PC      = a_pc;
        end else if (w_grant_b) begin
            writeEn = 1'b1;
            WAddr   = w_head.addr;
            WData   = w_head.data;
            PC      = w_head.pc;
        end
    end

    assign stall = reset && (r_state == c_FORCE);

`ifdef GRF_ARB_HAZARD_EN
    always_comb begin
        q_hazard = 1'b0;
        if (reset && (q_addr != c_ADDR_ZERO)) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                if (w_valid[i] && (w_addr_tap[i] == q_addr)) begin
                    q_hazard = 1'b1;
                end
            end
            if (w_b_accept && (b_addr == q_addr)) begin
                q_hazard = 1'b1;
            end
        end
    end
`else
    assign q_hazard = 1'b0;

    // Query inputs and entry taps have no consumer in this build
    logic w_unused_hazard;
    assign w_unused_hazard = ^{q_addr, w_valid, w_addr_tap};
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_wport_arbiter
// Description : Self-checking bench for grf_wport_arbiter. Every write the
//               bench expects is queued when stimulus is driven (A and B in
//               separate queues, told apart by PC bit 31) and popped by a
//               monitor thread whenever writeEn is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wport_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

`ifdef GRF_ARB_HAZARD_EN
    localparam logic c_HZ = 1'b1;
`else
    localparam logic c_HZ = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic        b_ready;
    logic        writeEn;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic [31:0] PC;
    logic        stall;
    logic [4:0]  q_addr;
    logic        q_hazard;

    int  n_assert;
    int  n_fail;
    wr_t qa[$];
    wr_t qb[$];

    grf_wport_arbiter #(.MAX_WAIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_pc     (a_pc),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_pc     (b_pc),
        .b_ready  (b_ready),
        .writeEn  (writeEn),
        .WAddr    (WAddr),
        .WData    (WData),
        .PC       (PC),
        .stall    (stall),
        .q_addr   (q_addr),
        .q_hazard (q_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge with all requesters idle
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            a_we = 1'b0; a_addr = '0; a_data = '0; a_pc = '0;
            b_valid = 1'b0; b_addr = '0; b_data = '0; b_pc = '0;
        end
    endtask

    task automatic drive_a(input logic [4:0] ad, input logic [31:0] d, input logic expect_write);
        a_we = 1'b1; a_addr = ad; a_data = d; a_pc = {1'b0, 26'd0, ad};
        if (expect_write) qa.push_back('{addr: ad, data: d, pc: {1'b0, 26'd0, ad}});
    endtask

    task automatic drive_b(input logic [4:0] ad, input logic [31:0] d, input logic expect_write);
        b_valid = 1'b1; b_addr = ad; b_data = d; b_pc = {1'b1, 26'd0, ad};
        if (expect_write) qb.push_back('{addr: ad, data: d, pc: {1'b1, 26'd0, ad}});
    endtask

    task automatic test_reset();
        // Reset held with A asserted: outputs must still be at reset values
        drive_a(5'd5, 32'h1, 1'b0);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0 || stall !== 1'b0 || b_ready !== 1'b1 || q_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: we=%b stall=%b ready=%b hz=%b, expected 0 0 1 0",
                     writeEn, stall, b_ready, q_hazard);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_we = 1'b0; a_addr = '0; a_data = '0; a_pc = '0;
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0 || stall !== 1'b0 || b_ready !== 1'b1 || q_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: we=%b stall=%b ready=%b hz=%b, expected 0 0 1 0",
                     writeEn, stall, b_ready, q_hazard);
        end
    endtask

    task automatic test_a_write();
        @(posedge clk);
        #1;
        drive_a(5'd5, 32'h1234, 1'b1);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b1 || WAddr !== 5'd5 || WData !== 32'h1234 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL a_zero_latency: we=%b addr=%0d data=%h stall=%b, expected 1 5 00001234 0",
                     writeEn, WAddr, WData, stall);
        end
        idle(2);
    endtask

    task automatic test_b_latency();
        drive_b(5'd7, 32'hAA, 1'b1);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_push_cycle: we=%b ready=%b, expected 0 1", writeEn, b_ready);
        end
        idle(1);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b1 || WAddr !== 5'd7 || WData !== 32'hAA) begin
            n_fail++;
            $display("FAIL b_latency1: we=%b addr=%0d data=%h, expected 1 7 000000aa", writeEn, WAddr, WData);
        end
        idle(1);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL b_drained: we=%b addr=%0d, expected we 0", writeEn, WAddr);
        end
        idle(1);
    endtask

    task automatic test_fifo_full();
        logic found;
        drive_a(5'd1, 32'h11, 1'b1);
        drive_b(5'd3, 32'h33, 1'b1);
        idle(1);
        drive_a(5'd2, 32'h22, 1'b1);
        drive_b(5'd4, 32'h44, 1'b1);
        idle(1);
        drive_a(5'd6, 32'h66, 1'b1);
        drive_b(5'd5, 32'h55, 1'b1);
        @(negedge clk);
        n_assert++;
        if (b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: ready=%b, expected 0", b_ready);
        end
        // Hold the third request until it is accepted
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1;
            a_we = 1'b0; a_addr = '0; a_data = '0; a_pc = '0;
            @(negedge clk);
            if (b_ready === 1'b1) found = 1'b1;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL full_wait_ready: ready=%b after 8 cycles, expected 1", b_ready);
        end
        idle(4);
    endtask

    task automatic test_force();
        drive_b(5'd9, 32'h99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            drive_a(5'(10 + i), 32'(16'hA000 + i), 1'b1);
            @(negedge clk);
            n_assert++;
            if (stall !== 1'b0 || WAddr !== 5'(10 + i)) begin
                n_fail++;
                $display("FAIL force_blocked%0d: stall=%b addr=%0d, expected 0 %0d", i, stall, WAddr, 10 + i);
            end
        end
        idle(1);
        drive_a(5'd20, 32'hBAD, 1'b0);
        @(negedge clk);
        n_assert++;
        if (stall !== 1'b1 || writeEn !== 1'b1 || WAddr !== 5'd9 || WData !== 32'h99) begin
            n_fail++;
            $display("FAIL force_cycle: stall=%b we=%b addr=%0d data=%h, expected 1 1 9 00000099",
                     stall, writeEn, WAddr, WData);
        end
        idle(1);
        drive_a(5'd21, 32'h2121, 1'b1);
        @(negedge clk);
        n_assert++;
        if (stall !== 1'b0 || WAddr !== 5'd21) begin
            n_fail++;
            $display("FAIL force_exit: stall=%b addr=%0d, expected 0 21", stall, WAddr);
        end
        idle(2);
    endtask

    task automatic test_addr_zero();
        drive_b(5'd0, 32'hDEAD, 1'b0);
        @(negedge clk);
        n_assert++;
        if (b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_b_accept: ready=%b, expected 1", b_ready);
        end
        idle(1);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_b_nowrite: we=%b addr=%0d, expected 0", writeEn, WAddr);
        end
        drive_b(5'd14, 32'hE, 1'b1);
        idle(1);
        drive_a(5'd0, 32'h5555, 1'b0);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b1 || WAddr !== 5'd14 || WData !== 32'hE) begin
            n_fail++;
            $display("FAIL zero_a_drain: we=%b addr=%0d data=%h, expected 1 14 0000000e", writeEn, WAddr, WData);
        end
        idle(1);
        drive_a(5'd0, 32'h5555, 1'b0);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_a_nowrite: we=%b addr=%0d, expected 0", writeEn, WAddr);
        end
        idle(2);
    endtask

    task automatic test_hazard_reset();
        q_addr = 5'd12;
        drive_a(5'd1, 32'h1, 1'b1);
        drive_b(5'd12, 32'hC, 1'b0);
        @(negedge clk);
        n_assert++;
        if (q_hazard !== c_HZ) begin
            n_fail++;
            $display("FAIL hazard_incoming: hz=%b, expected %b", q_hazard, c_HZ);
        end
        idle(1);
        drive_a(5'd2, 32'h2, 1'b1);
        @(negedge clk);
        n_assert++;
        if (q_hazard !== c_HZ) begin
            n_fail++;
            $display("FAIL hazard_queued: hz=%b, expected %b", q_hazard, c_HZ);
        end
        q_addr = 5'd13;
        #1;
        n_assert++;
        if (q_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_other: hz=%b, expected 0", q_hazard);
        end
        q_addr = 5'd12;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_a(5'd3, 32'h3, 1'b0);
        @(negedge clk);
        n_assert++;
        if (writeEn !== 1'b0 || q_hazard !== 1'b0 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_in_reset: we=%b hz=%b ready=%b, expected 0 0 1", writeEn, q_hazard, b_ready);
        end
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        n_assert++;
        if (q_hazard !== 1'b0 || writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_after_reset: hz=%b we=%b, expected 0 0", q_hazard, writeEn);
        end
        idle(6);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        a_we = 1'b0; a_addr = '0; a_data = '0; a_pc = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0; b_pc = '0;
        q_addr = '0;

        // Scoreboard monitor: every write must match the oldest expectation
        fork
            begin
                wr_t exp_w;
                forever begin
                    @(negedge clk);
                    n_assert++;
                    if (writeEn === 1'b1) begin
                        if (PC[31] ? (qb.size() == 0) : (qa.size() == 0)) begin
                            n_fail++;
                            $display("FAIL sb_unexpected: got addr=%0d data=%h pc=%h, expected no write",
                                     WAddr, WData, PC);
                        end else begin
                            exp_w = PC[31] ? qb.pop_front() : qa.pop_front();
                            if ({WAddr, WData, PC} !== exp_w) begin
                                n_fail++;
                                $display("FAIL sb_write: got addr=%0d data=%h pc=%h, expected addr=%0d data=%h pc=%h",
                                         WAddr, WData, PC, exp_w.addr, exp_w.data, exp_w.pc);
                            end
                        end
                    end else if ({WAddr, WData, PC} !== '0) begin
                        n_fail++;
                        $display("FAIL sb_idle_zero: got addr=%0d data=%h pc=%h, expected all 0",
                                 WAddr, WData, PC);
                    end
                end
            end
        join_none

        test_reset();
        test_a_write();
        test_b_latency();
        test_fifo_full();
        test_force();
        test_addr_zero();
        test_hazard_reset();

        n_assert++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d A and %0d B writes outstanding, expected 0 0",
                     qa.size(), qb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
